// File: rtl/sata_device_oob_if.sv
// sata_device_oob_if: GTX OOB/8b10b and link-layer signals of the device OOB controller.
// The slave modport is the controller; the master modport is whatever drives it (PHY model, bench).
interface sata_device_oob_if;
  logic        rx_locked;
  logic [1:0]  gen;
  logic        comresetdet;
  logic        comwakedet;
  logic        rxelecidle;
  logic        rxbyteisaligned;
  logic [31:0] rx_datain;
  logic [3:0]  rx_charisk;
  logic [31:0] tx_datain;
  logic [3:0]  tx_chariskin;
  logic [31:0] tx_dataout;
  logic [3:0]  tx_charisk_out;
  logic        txcominit;
  logic        txcomwake;
  logic        txelecidle;
  logic        linkup;
  logic [3:0]  state_out;
  modport master (
    output rx_locked, gen, comresetdet, comwakedet, rxelecidle, rxbyteisaligned,
           rx_datain, rx_charisk, tx_datain, tx_chariskin,
    input  tx_dataout, tx_charisk_out, txcominit, txcomwake, txelecidle, linkup, state_out
  );
  modport slave (
    input  rx_locked, gen, comresetdet, comwakedet, rxelecidle, rxbyteisaligned,
           rx_datain, rx_charisk, tx_datain, tx_chariskin,
    output tx_dataout, tx_charisk_out, txcominit, txcomwake, txelecidle, linkup, state_out
  );
endinterface

// File: rtl/sata_device_oob.sv
// sata_device_oob: device-side OOB responder; answers COMRESET with COMINIT, COMWAKE with COMWAKE,
// then exchanges ALIGN and SYNC with the host before raising linkup.
module sata_device_oob #(
  parameter int unsigned QUIET_CYCLES    = 32,
  parameter logic [17:0] TIMEOUT_CYCLES  = 18'h203AD,
  parameter int unsigned SYNC_STABLE_CNT = 50,
  parameter int unsigned LOSS_CYCLES     = 64
) (
  input logic              clk,
  input logic              reset,
  sata_device_oob_if.slave bus
);
  typedef enum logic [3:0] {
    DEV_IDLE           = 4'd0,
    WAIT_HOST_COMRESET = 4'd1,
    WAIT_COMRESET_END  = 4'd2,
    DEV_COMINIT        = 4'd3,
    WAIT_HOST_COMWAKE  = 4'd4,
    WAIT_COMWAKE_END   = 4'd5,
    DEV_COMWAKE        = 4'd6,
    DEV_SEND_ALIGN     = 4'd7,
    DEV_SEND_SYNC      = 4'd8,
    LINK_READY         = 4'd9
  } state_t;
  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_W  = 32'hB5B5957C;
  localparam logic [31:0] D102_W  = 32'h4A4A4A4A;
  localparam logic [3:0]  K_PRIM  = 4'b0001;
  localparam logic [15:0] QUIET_N = 16'(QUIET_CYCLES);
  localparam logic [15:0] SYNC_N  = 16'(SYNC_STABLE_CNT);
  localparam logic [15:0] LOSS_N  = 16'(LOSS_CYCLES);
  localparam logic [15:0] ALIGN_N = 16'd3;
  state_t      state_q, state_d;
  logic [17:0] cnt_q, cominit_len, comwake_len;
  logic [15:0] run_q, run_d;
  logic [31:0] rx_data_q, tx_data_q;
  logic [3:0]  rx_k_q, tx_k_q;
  logic        txcominit_q, txcomwake_q, txelecidle_q, linkup_q;
  logic        align_word, align_det, sync_det, run_inc, run_hold, timeout;
  assign align_word  = rx_data_q == ALIGN_W && rx_k_q == K_PRIM;
  assign align_det   = align_word && bus.rxbyteisaligned;
  assign sync_det    = rx_data_q == SYNC_W && rx_k_q == K_PRIM;
  assign cominit_len = bus.gen == 2'b00 ? 18'h51 : bus.gen == 2'b01 ? 18'hA2 : 18'h144;
  assign comwake_len = bus.gen == 2'b00 ? 18'h4E : bus.gen == 2'b01 ? 18'h9B : 18'h136;
  assign timeout     = cnt_q >= TIMEOUT_CYCLES - 18'd1;
  // One shared run counter: quiet time, ALIGN run, SYNC run or idle-loss run depending on state
  assign run_inc  = state_q == WAIT_COMRESET_END ? bus.rxelecidle && !bus.comresetdet :
                    state_q == DEV_SEND_ALIGN    ? align_det :
                    state_q == DEV_SEND_SYNC     ? sync_det :
                    state_q == LINK_READY && bus.rxelecidle;
  assign run_hold = state_q == DEV_SEND_SYNC && align_word;
  assign run_d    = run_hold ? run_q : !run_inc ? '0 : run_q == '1 ? run_q : run_q + 16'd1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEV_IDLE:           state_d = WAIT_HOST_COMRESET;
      WAIT_HOST_COMRESET: state_d = bus.comresetdet ? WAIT_COMRESET_END : state_q;
      WAIT_COMRESET_END:  state_d = run_d == QUIET_N ? DEV_COMINIT : state_q;
      DEV_COMINIT:        state_d = cnt_q >= cominit_len - 18'd1 ? WAIT_HOST_COMWAKE : state_q;
      WAIT_HOST_COMWAKE:  state_d = bus.comwakedet ? WAIT_COMWAKE_END : timeout ? WAIT_HOST_COMRESET : state_q;
      WAIT_COMWAKE_END:   state_d = bus.comwakedet ? state_q : DEV_COMWAKE;
      DEV_COMWAKE:        state_d = cnt_q >= comwake_len - 18'd1 ? DEV_SEND_ALIGN : state_q;
      DEV_SEND_ALIGN:     state_d = run_d == ALIGN_N ? DEV_SEND_SYNC : timeout ? WAIT_HOST_COMRESET : state_q;
      DEV_SEND_SYNC:      state_d = run_d == SYNC_N ? LINK_READY : state_q;
      LINK_READY:         state_d = run_d == LOSS_N ? WAIT_HOST_COMRESET : state_q;
      default:            state_d = DEV_IDLE;
    endcase
    if (bus.comresetdet && state_q inside {[DEV_COMINIT:LINK_READY]}) state_d = WAIT_COMRESET_END;
    if (!bus.rx_locked) state_d = DEV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DEV_IDLE;
      cnt_q        <= '0;
      run_q        <= '0;
      rx_data_q    <= '0;
      rx_k_q       <= '0;
      tx_data_q    <= '0;
      tx_k_q       <= '0;
      txcominit_q  <= 1'b0;
      txcomwake_q  <= 1'b0;
      txelecidle_q <= 1'b1;
      linkup_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= state_d != state_q ? '0 : cnt_q == '1 ? cnt_q : cnt_q + 18'd1;
      run_q        <= state_d != state_q ? '0 : run_d;
      rx_data_q    <= bus.rx_datain;
      rx_k_q       <= bus.rx_charisk;
      tx_data_q    <= state_q == DEV_SEND_ALIGN ? ALIGN_W : state_q == DEV_SEND_SYNC ? SYNC_W :
                      state_q == LINK_READY ? bus.tx_datain : D102_W;
      tx_k_q       <= state_q inside {DEV_SEND_ALIGN, DEV_SEND_SYNC} ? K_PRIM :
                      state_q == LINK_READY ? bus.tx_chariskin : 4'b0000;
      // Moore outputs are registered from the next state so they line up with state_q
      txcominit_q  <= state_d == DEV_COMINIT;
      txcomwake_q  <= state_d == DEV_COMWAKE;
      txelecidle_q <= !(state_d inside {DEV_SEND_ALIGN, DEV_SEND_SYNC, LINK_READY});
      linkup_q     <= state_d == LINK_READY;
    end
  end
  assign bus.tx_dataout     = tx_data_q;
  assign bus.tx_charisk_out = tx_k_q;
  assign bus.txcominit      = txcominit_q;
  assign bus.txcomwake      = txcomwake_q;
  assign bus.txelecidle     = txelecidle_q;
  assign bus.linkup         = linkup_q;
  assign bus.state_out      = state_q;
endmodule
